cra_seq: RTL and testbench
==========================

Name: cra_seq

Overview:
- Microcode address sequencer (CRA-equivalent), directly upstream of the 2K-word CRAM store.
- Each cycle it computes the next CRADR from the current microword's J, DISP/SPEC, SKIP/COND and CALL fields, plus condition and dispatch inputs from the EBOX.
- Holds a subroutine return stack and supports hold/stall and a console forced-address load.
- CRADR is registered and drives the CRAM address directly.

Parameters:
- ADR_W, 11: CRAM address width. CRADR output is zero-extended to 12 bits.
- STACK_DEPTH, 16: return-stack entries (power of two).
- DISP_W, 4: width of the dispatch data input ORed into the low address bits.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- CRAM_J  input  12  next-address field of the current microword; bits [ADR_W-1:0] used
- CRAM_CALL  input  1  current word is a subroutine call
- CRAM_DISP  input  6  dispatch select for the current word
- CRAM_SKIP  input  7  skip condition select; 0 means no skip
- skip_true  input  1  EBOX evaluation of the selected skip condition
- disp_data  input  DISP_W  EBOX dispatch value (DRAM J low bits, SH/AR field, etc.)
- hold  input  1  stall: freeze CRADR and stack
- con_load  input  1  console forced load of CRADR
- con_adr  input  ADR_W  console address
- CRADR  output  12  registered CRAM address
- stack_err  output  1  sticky stack overflow/underflow (see Optional Feature)

Behaviour:
- Reset (synchronous): CRADR=0, stack pointer=0, all stack entries=0, stack_err=0. Reset wins over every other input.
- Priority each rising edge: reset > con_load > hold > normal sequencing.
  - con_load: CRADR<=con_adr. Stack and pointer unchanged. Ignores hold.
  - hold: CRADR, stack and pointer all unchanged.
- Field timing: the CRAM read is synchronous, so the field inputs describe the word at the CRADR value presented one cycle earlier. The sequencer does not re-time them.
- Normal next address NA starts as CRAM_J[ADR_W-1:0], then is modified by CRAM_DISP:
  - 6'o00 (NONE): NA unchanged.
  - 6'o01 (DISP): NA = J | zero-extended disp_data.
  - 6'o02 (DISP2): NA = J | disp_data[1:0].
  - 6'o41 (RETURN): pop; NA = popped entry | J. Pointer decrements.
  - Any other code: treated as NONE.
- Skip: if CRAM_SKIP!=0 and skip_true=1, NA[0] is set (OR). This applies after dispatch, including RETURN.
- CALL=1: push the current CRADR, then the pointer increments. CRADR<=NA.
- CALL and RETURN in the same word: pop happens first (the popped value forms NA), then the current CRADR is pushed into the freed slot. Net pointer change is 0.
- Arithmetic: OR only, no carries. Addresses wrap modulo 2^ADR_W. The pointer wraps modulo STACK_DEPTH.
- Full push (pointer==STACK_DEPTH): the oldest entry is overwritten (ring). Empty pop: returns the entry at the wrapped pointer.
- Latency: one clock from field inputs to CRADR update. No combinational path from inputs to CRADR.

Optional Feature:
- Macro CRA_STACK_CHECK_EN.
- Defined: track an occupancy count 0..STACK_DEPTH.
  - Push at full or pop at empty sets stack_err, which stays set until reset.
  - Addressing behaviour is unchanged.
  - A simultaneous pop+push never flags.
- Undefined: no occupancy counter; stack_err tied to 0.

Decomposition:
- Package cra_pkg holds:
  - localparams for DISP codes: DISP_NONE=6'o00, DISP_DISP=6'o01, DISP_DISP2=6'o02, DISP_RETURN=6'o41
  - ADR_W default
  - typedef cradr_t
- One sub-module, cra_stack: a register-file LIFO with push/pop/pop+push, pointer and optional occupancy.
- Next-address combinational logic stays in cra_seq.

Test Plan:
- Reset then J=12'o0100, DISP=00, SKIP=0 → CRADR=0 after reset, 12'o0100 one cycle later; hold=1 for 3 cycles keeps 12'o0100.
- J=12'o0200, DISP=01, disp_data=4'hA → CRADR=12'o0212; same word with SKIP=5, skip_true=1 → 12'o0213.
- At CRADR=12'o0300: CALL=1, J=12'o1000. Then next word DISP=41, J=12'o0001 → CRADR 12'o1000, then 12'o0301 (return+1).
- 17 nested calls without returns (DEPTH=16) → with CRA_STACK_CHECK_EN, stack_err rises on the 17th push and stays set; without the macro it stays 0. A RETURN from the empty stack after reset flags likewise.
- con_load=1, con_adr=11'o1777 while hold=1 → CRADR=12'o1777 next cycle and the stack pointer is unchanged. reset asserted mid-call sequence → CRADR=0, following RETURN yields 0|J.

Source files
------------

// File: rtl/cra_pkg.sv
// Shared definitions for the CRAM address sequencer: dispatch codes,
// default address width and the CRAM address type.
package cra_pkg;

  localparam int ADR_W_DEF   = 11;
  localparam int CRADR_OUT_W = 12;

  localparam logic [5:0] DISP_NONE   = 6'o00;
  localparam logic [5:0] DISP_DISP   = 6'o01;
  localparam logic [5:0] DISP_DISP2  = 6'o02;
  localparam logic [5:0] DISP_RETURN = 6'o41;

  typedef logic [ADR_W_DEF-1:0] cradr_t;

endpackage

// File: rtl/cra_if.sv
// Bundle of microword fields, EBOX inputs, console controls and the CRAM
// address returned by the sequencer. master = EBOX/console side,
// slave = sequencer.
interface cra_if
  import cra_pkg::*;
#(
  parameter int ADR_W  = ADR_W_DEF,
  parameter int DISP_W = 4
);

  logic [11:0]       CRAM_J;
  logic              CRAM_CALL;
  logic [5:0]        CRAM_DISP;
  logic [6:0]        CRAM_SKIP;
  logic              skip_true;
  logic [DISP_W-1:0] disp_data;
  logic              hold;
  logic              con_load;
  logic [ADR_W-1:0]  con_adr;
  logic [11:0]       CRADR;
  logic              stack_err;

  modport master (
    output CRAM_J, CRAM_CALL, CRAM_DISP, CRAM_SKIP, skip_true, disp_data,
           hold, con_load, con_adr,
    input  CRADR, stack_err
  );

  modport slave (
    input  CRAM_J, CRAM_CALL, CRAM_DISP, CRAM_SKIP, skip_true, disp_data,
           hold, con_load, con_adr,
    output CRADR, stack_err
  );

endinterface

// File: rtl/cra_stack.sv
// Subroutine return stack: register-file ring LIFO with push, pop and
// combined pop+push (replace top). Pop data is read combinationally from
// the entry below the pointer so it can feed the next address this cycle.
// Optional occupancy checking is enabled by defining CRA_STACK_CHECK_EN.
module cra_stack
  import cra_pkg::*;
#(
  parameter int ADR_W       = ADR_W_DEF,
  parameter int STACK_DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [ADR_W-1:0] push_data,
  output logic [ADR_W-1:0] pop_data,
  output logic             stack_err
);

  localparam int PTR_W = $clog2(STACK_DEPTH);

  logic [ADR_W-1:0] mem_reg [STACK_DEPTH];
  logic [PTR_W-1:0] sp_reg;
  logic [PTR_W-1:0] sp_next;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W-1:0] wr_idx;

  // Top-of-stack index wraps below zero, so an empty pop reads the last slot.
  assign top_idx  = sp_reg - 1'b1;
  assign pop_data = mem_reg[top_idx];
  // Pop+push rewrites the slot just freed by the pop.
  assign wr_idx   = pop ? top_idx : sp_reg;

  // Pointer moves only for a lone push or a lone pop.
  always_comb begin
    sp_next = sp_reg;
    if (push && !pop)
      sp_next = sp_reg + 1'b1;
    else if (pop && !push)
      sp_next = sp_reg - 1'b1;
  end

  // Stack pointer register.
  always_ff @(posedge clk) begin
    if (reset)
      sp_reg <= '0;
    else
      sp_reg <= sp_next;
  end

  // One register per entry, cleared on reset, written when selected by a push.
  generate
    for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (reset)
          mem_reg[gi] <= '0;
        else if (push && (wr_idx == PTR_W'(gi)))
          mem_reg[gi] <= push_data;
      end
    end
  endgenerate

`ifdef CRA_STACK_CHECK_EN
  logic [PTR_W:0] occ_reg;
  logic           err_reg;

  // Occupancy tracking; overflow/underflow latch the sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_reg <= '0;
      err_reg <= 1'b0;
    end else if (push && !pop) begin
      if (occ_reg == (PTR_W+1)'(STACK_DEPTH))
        err_reg <= 1'b1;
      else
        occ_reg <= occ_reg + 1'b1;
    end else if (pop && !push) begin
      if (occ_reg == '0)
        err_reg <= 1'b1;
      else
        occ_reg <= occ_reg - 1'b1;
    end
  end

  assign stack_err = err_reg;
`else
  assign stack_err = 1'b0;
`endif

endmodule

// File: rtl/cra_seq.sv
// Microcode address sequencer feeding the CRAM address. Computes the next
// address from J, dispatch, skip and call fields of the current word, with
// console forced load and hold. Optional stack checking: CRA_STACK_CHECK_EN.
module cra_seq
  import cra_pkg::*;
#(
  parameter int ADR_W       = ADR_W_DEF,
  parameter int STACK_DEPTH = 16,
  parameter int DISP_W      = 4
) (
  input logic  clk,
  input logic  reset,
  cra_if.slave bus
);

  logic [ADR_W-1:0]  cradr_reg;
  logic [ADR_W-1:0]  cradr_next;
  logic [ADR_W-1:0]  j_adr;
  logic [ADR_W-1:0]  pop_data;
  logic [DISP_W-1:0] disp_val;
  logic              advance;
  logic              do_push;
  logic              do_pop;
  logic              unused_j_hi;

  assign j_adr       = bus.CRAM_J[ADR_W-1:0];
  assign unused_j_hi = ^bus.CRAM_J[11:ADR_W];
  assign disp_val    = bus.disp_data;

  // Stack only moves when the sequencer actually steps to the next word.
  assign advance = !bus.con_load && !bus.hold;
  assign do_push = advance && bus.CRAM_CALL;
  assign do_pop  = advance && (bus.CRAM_DISP == DISP_RETURN);

  // Next-address formation: OR-only merging, then skip sets bit 0.
  always_comb begin
    cradr_next = j_adr;
    case (bus.CRAM_DISP)
      DISP_DISP:   cradr_next = j_adr | ADR_W'(disp_val);
      DISP_DISP2:  cradr_next = j_adr | ADR_W'(disp_val[1:0]);
      DISP_RETURN: cradr_next = j_adr | pop_data;
      default:     cradr_next = j_adr;
    endcase
    if ((bus.CRAM_SKIP != 7'd0) && bus.skip_true)
      cradr_next[0] = 1'b1;
  end

  // CRAM address register: console load beats hold, hold freezes.
  always_ff @(posedge clk) begin
    if (reset)
      cradr_reg <= '0;
    else if (bus.con_load)
      cradr_reg <= bus.con_adr;
    else if (!bus.hold)
      cradr_reg <= cradr_next;
  end

  cra_stack #(
    .ADR_W       (ADR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (do_push),
    .pop       (do_pop),
    .push_data (cradr_reg),
    .pop_data  (pop_data),
    .stack_err (bus.stack_err)
  );

  assign bus.CRADR = CRADR_OUT_W'(cradr_reg);

endmodule

// File: tb/tb_cra_seq.sv
// Directed bench for the CRAM address sequencer. Expected stack_err follows
// CRA_STACK_CHECK_EN when it is defined for the build.
module tb_cra_seq;
  import cra_pkg::*;

`ifdef CRA_STACK_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  cra_if bus ();

  cra_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    $display("t=%0t reset=%0b hold=%0b con_load=%0b J=%o call=%0b disp=%o skip=%0d st=%0b dd=%h -> CRADR=%o err=%0b",
             $time, reset, bus.hold, bus.con_load, bus.CRAM_J, bus.CRAM_CALL,
             bus.CRAM_DISP, bus.CRAM_SKIP, bus.skip_true, bus.disp_data,
             bus.CRADR, bus.stack_err);
  endtask

  // Present one microword and clock it in.
  task automatic word(input logic [11:0] j, input logic call, input logic [5:0] disp,
                      input logic [6:0] skip, input logic st, input logic [3:0] dd);
    bus.CRAM_J    = j;
    bus.CRAM_CALL = call;
    bus.CRAM_DISP = disp;
    bus.CRAM_SKIP = skip;
    bus.skip_true = st;
    bus.disp_data = dd;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    word(12'o0, 1'b0, 6'o00, 7'd0, 1'b0, 4'h0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.CRADR !== 12'o0000) begin
      $display("FAIL reset_cradr got=%o exp=%o", bus.CRADR, 12'o0000); errors++;
    end
    checks++;
    if (bus.stack_err !== 1'b0) begin
      $display("FAIL reset_err got=%0b exp=0", bus.stack_err); errors++;
    end
  endtask

  task automatic test_jump_hold();
    word(12'o0100, 1'b0, 6'o00, 7'd0, 1'b0, 4'h0);
    checks++;
    if (bus.CRADR !== 12'o0100) begin
      $display("FAIL jump got=%o exp=%o", bus.CRADR, 12'o0100); errors++;
    end
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      word(12'o0555, 1'b1, 6'o41, 7'd0, 1'b0, 4'h0);
      checks++;
      if (bus.CRADR !== 12'o0100) begin
        $display("FAIL hold_%0d got=%o exp=%o", i, bus.CRADR, 12'o0100); errors++;
      end
    end
    bus.hold = 1'b0;
  endtask

  task automatic test_dispatch();
    logic [11:0] exp_tab [5];
    logic [5:0]  disp_tab [5];
    logic [6:0]  skip_tab [5];
    logic        st_tab [5];
    exp_tab  = '{12'o0212, 12'o0213, 12'o0212, 12'o0202, 12'o0200};
    disp_tab = '{6'o01,    6'o01,    6'o01,    6'o02,    6'o03};
    skip_tab = '{7'd0,     7'd5,     7'd5,     7'd0,     7'd0};
    st_tab   = '{1'b0,     1'b1,     1'b0,     1'b0,     1'b0};
    for (int i = 0; i < 5; i++) begin
      word(12'o0200, 1'b0, disp_tab[i], skip_tab[i], st_tab[i], 4'hA);
      checks++;
      if (bus.CRADR !== exp_tab[i]) begin
        $display("FAIL dispatch_%0d got=%o exp=%o", i, bus.CRADR, exp_tab[i]); errors++;
      end
    end
  endtask

  task automatic test_call_return();
    word(12'o0300, 1'b0, 6'o00, 7'd0, 1'b0, 4'h0);
    word(12'o1000, 1'b1, 6'o00, 7'd0, 1'b0, 4'h0);
    checks++;
    if (bus.CRADR !== 12'o1000) begin
      $display("FAIL call got=%o exp=%o", bus.CRADR, 12'o1000); errors++;
    end
    word(12'o0001, 1'b0, 6'o41, 7'd0, 1'b0, 4'h0);
    checks++;
    if (bus.CRADR !== 12'o0301) begin
      $display("FAIL return got=%o exp=%o", bus.CRADR, 12'o0301); errors++;
    end
    // Call+return in one word: pop 0400 forms NA, 0500 replaces it.
    word(12'o0400, 1'b0, 6'o00, 7'd0, 1'b0, 4'h0);
    word(12'o0500, 1'b1, 6'o00, 7'd0, 1'b0, 4'h0);
    word(12'o0002, 1'b1, 6'o41, 7'd0, 1'b0, 4'h0);
    checks++;
    if (bus.CRADR !== 12'o0402) begin
      $display("FAIL call_ret got=%o exp=%o", bus.CRADR, 12'o0402); errors++;
    end
    word(12'o0000, 1'b0, 6'o41, 7'd1, 1'b1, 4'h0);
    checks++;
    if (bus.CRADR !== 12'o0501) begin
      $display("FAIL ret_skip got=%o exp=%o", bus.CRADR, 12'o0501); errors++;
    end
    checks++;
    if (bus.stack_err !== 1'b0) begin
      $display("FAIL balanced_err got=%0b exp=0", bus.stack_err); errors++;
    end
  endtask

  task automatic test_con_load();
    word(12'o0600, 1'b1, 6'o00, 7'd0, 1'b0, 4'h0);   // pushes 0501
    bus.hold     = 1'b1;
    bus.con_load = 1'b1;
    bus.con_adr  = 11'o1777;
    word(12'o0070, 1'b1, 6'o41, 7'd0, 1'b0, 4'h0);
    bus.hold     = 1'b0;
    bus.con_load = 1'b0;
    checks++;
    if (bus.CRADR !== 12'o1777) begin
      $display("FAIL con_load got=%o exp=%o", bus.CRADR, 12'o1777); errors++;
    end
    word(12'o0000, 1'b0, 6'o41, 7'd0, 1'b0, 4'h0);
    checks++;
    if (bus.CRADR !== 12'o0501) begin
      $display("FAIL con_load_stack got=%o exp=%o", bus.CRADR, 12'o0501); errors++;
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      word(12'(k), 1'b1, 6'o00, 7'd0, 1'b0, 4'h0);
      checks++;
      if (bus.CRADR !== 12'(k)) begin
        $display("FAIL ovf_call_%0d got=%o exp=%o", k, bus.CRADR, 12'(k)); errors++;
      end
      checks++;
      if (bus.stack_err !== ((k == 17) ? CHK : 1'b0)) begin
        $display("FAIL ovf_err_%0d got=%0b exp=%0b", k, bus.stack_err, (k == 17) ? CHK : 1'b0); errors++;
      end
    end
    // Ring overwrote the oldest slot with 16; then 15 sits below it.
    word(12'o0000, 1'b0, 6'o41, 7'd0, 1'b0, 4'h0);
    checks++;
    if (bus.CRADR !== 12'd16) begin
      $display("FAIL ovf_ret0 got=%o exp=%o", bus.CRADR, 12'd16); errors++;
    end
    word(12'o0000, 1'b0, 6'o41, 7'd0, 1'b0, 4'h0);
    checks++;
    if (bus.CRADR !== 12'd15) begin
      $display("FAIL ovf_ret1 got=%o exp=%o", bus.CRADR, 12'd15); errors++;
    end
    checks++;
    if (bus.stack_err !== CHK) begin
      $display("FAIL ovf_sticky got=%0b exp=%0b", bus.stack_err, CHK); errors++;
    end
  endtask

  task automatic test_empty_pop();
    do_reset();
    word(12'o0005, 1'b0, 6'o41, 7'd0, 1'b0, 4'h0);
    checks++;
    if (bus.CRADR !== 12'o0005) begin
      $display("FAIL empty_pop got=%o exp=%o", bus.CRADR, 12'o0005); errors++;
    end
    checks++;
    if (bus.stack_err !== CHK) begin
      $display("FAIL empty_err got=%0b exp=%0b", bus.stack_err, CHK); errors++;
    end
  endtask

  task automatic test_reset_mid();
    word(12'o0700, 1'b1, 6'o00, 7'd0, 1'b0, 4'h0);
    reset = 1'b1;
    word(12'o0710, 1'b1, 6'o00, 7'd0, 1'b0, 4'h0);
    reset = 1'b0;
    checks++;
    if (bus.CRADR !== 12'o0000) begin
      $display("FAIL mid_reset got=%o exp=%o", bus.CRADR, 12'o0000); errors++;
    end
    checks++;
    if (bus.stack_err !== 1'b0) begin
      $display("FAIL mid_reset_err got=%0b exp=0", bus.stack_err); errors++;
    end
    // Pop+push on an empty stack never flags.
    word(12'o0010, 1'b1, 6'o41, 7'd0, 1'b0, 4'h0);
    checks++;
    if (bus.CRADR !== 12'o0010 || bus.stack_err !== 1'b0) begin
      $display("FAIL popush_empty got=%o/%0b exp=%o/0", bus.CRADR, bus.stack_err, 12'o0010); errors++;
    end
    word(12'o0003, 1'b0, 6'o41, 7'd0, 1'b0, 4'h0);
    checks++;
    if (bus.CRADR !== 12'o0003) begin
      $display("FAIL ret_after_reset got=%o exp=%o", bus.CRADR, 12'o0003); errors++;
    end
    checks++;
    if (bus.stack_err !== CHK) begin
      $display("FAIL ret_after_reset_err got=%0b exp=%0b", bus.stack_err, CHK); errors++;
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.CRAM_J    = '0;
    bus.CRAM_CALL = 1'b0;
    bus.CRAM_DISP = '0;
    bus.CRAM_SKIP = '0;
    bus.skip_true = 1'b0;
    bus.disp_data = '0;
    bus.hold      = 1'b0;
    bus.con_load  = 1'b0;
    bus.con_adr   = '0;
    test_reset();
    test_jump_hold();
    test_dispatch();
    test_call_return();
    test_con_load();
    test_overflow();
    test_empty_pop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
